// File: rtl/ristretto_shift_sequencer.sv
`default_nettype none
//============================================================================
// Module   : ristretto_shift_sequencer
// Purpose  : Multi-cycle iterative shifter for the ristretto execute stage.
//            Accepts one shift request at a time and applies it in steps of
//            at most StepAmt bits per cycle. It then presents the result to
//            writeback until that result is accepted.
// Ports    : clk_i, rst_ni          - clock, async active-low reset
//            req_valid_i/ready_o    - request handshake
//            req_data_i             - operand (DataWidth bits)
//            req_amt_i              - shift amount ($clog2(DataWidth) bits)
//            req_mode_i             - 00/01 left, 10 logical right,
//                                     11 arithmetic right
//            kill_i                 - flush, aborts any request in flight
//            rsp_valid_o/ready_i    - response handshake
//            rsp_result_o           - shifted result
//            busy_o                 - unit is not idle
// Revision : 1.0 - initial release
//============================================================================
module ristretto_shift_sequencer #(
  parameter int DataWidth = 32,
  parameter int StepAmt   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [DataWidth-1:0]         req_data_i,
  input  logic [$clog2(DataWidth)-1:0] req_amt_i,
  input  logic [1:0]                   req_mode_i,
  input  logic                         kill_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DataWidth-1:0]         rsp_result_o,
  output logic                         busy_o
);

  localparam int c_amt_w = $clog2(DataWidth);

  // StepAmt <= DataWidth/2, so it always fits in the amount width.
  localparam logic [c_amt_w-1:0] c_step_max = c_amt_w'(StepAmt);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [DataWidth-1:0] r_data;
  logic [c_amt_w-1:0]   r_rem;
  logic                 r_right;   // direction: 1 = right shift
  logic                 r_fill;    // bit shifted in from the top on right shifts

  logic                 w_accept;
  logic [c_amt_w-1:0]   w_step;
  logic [DataWidth-1:0] w_shl;
  logic [DataWidth:0]   w_ext;
  logic signed [DataWidth:0] w_shr_ext;
  logic [DataWidth-1:0] w_shr;

  // A request arriving together with kill_i is void, even though
  // req_ready_o may be high in that cycle.
  assign w_accept = (r_state == c_st_idle) && req_valid_i && !kill_i;

  assign w_step = (r_rem > c_step_max) ? c_step_max : r_rem;

  // Right shifts use the fill bit as an extra sign bit on top of the data.
  // An arithmetic shift of that extended word then replicates the fill
  // value. This one path covers both SRL (fill 0) and SRA (fill = MSB).
  assign w_shl     = r_data << w_step;
  assign w_ext     = {r_fill, r_data};
  assign w_shr_ext = $signed(w_ext) >>> w_step;
  assign w_shr     = w_shr_ext[DataWidth-1:0];

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------
  // Next-state logic (kill has priority over everything)
  // --------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (kill_i) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (req_valid_i) begin
            w_state_nxt = (req_amt_i == '0) ? c_st_done : c_st_shift;
          end
        end
        c_st_shift: begin
          // This step consumes the remaining amount exactly.
          if (r_rem == w_step) begin
            w_state_nxt = c_st_done;
          end
        end
        c_st_done: begin
          if (rsp_ready_i) begin
            w_state_nxt = c_st_idle;
          end
        end
        default: w_state_nxt = c_st_idle;
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // --------------------------------------------------------------------
  always_comb begin
    req_ready_o  = (r_state == c_st_idle);
    rsp_valid_o  = (r_state == c_st_done);
    busy_o       = (r_state != c_st_idle);
    rsp_result_o = r_data;
  end

  // --------------------------------------------------------------------
  // Datapath: operand capture and per-cycle step
  // --------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_rem   <= '0;
      r_right <= 1'b0;
      r_fill  <= 1'b0;
    end else if (w_accept) begin
      r_data  <= req_data_i;
      r_rem   <= req_amt_i;
      r_right <= req_mode_i[1];
      r_fill  <= (req_mode_i == 2'b11) && req_data_i[DataWidth-1];
    end else if ((r_state == c_st_shift) && !kill_i) begin
      r_data  <= r_right ? w_shr : w_shl;
      r_rem   <= r_rem - w_step;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ristretto_shift_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : tb_ristretto_shift_sequencer
// Purpose  : Self-checking bench for ristretto_shift_sequencer.
//            A behavioural model computes the result arithmetically and the
//            response latency from a formula. A compare process checks the
//            handshake outputs against it on every cycle. Directed
//            requests pin the literal results and latencies.
// Revision : 1.0 - initial release
//============================================================================
module tb_ristretto_shift_sequencer;

  localparam int DW = 32;
  localparam int SA = 4;
  localparam int AW = $clog2(DW);

  logic          clk_i       = 1'b0;
  logic          rst_ni      = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          kill_i      = 1'b0;
  logic          rsp_ready_i = 1'b1;
  logic [DW-1:0] req_data_i  = '0;
  logic [AW-1:0] req_amt_i   = '0;
  logic [1:0]    req_mode_i  = '0;
  logic          req_ready_o;
  logic          rsp_valid_o;
  logic          busy_o;
  logic [DW-1:0] rsp_result_o;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk_i = ~clk_i;

  ristretto_shift_sequencer #(
    .DataWidth (DW),
    .StepAmt   (SA)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .req_amt_i    (req_amt_i),
    .req_mode_i   (req_mode_i),
    .kill_i       (kill_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input int amt,
                                              input logic [1:0] mode);
    logic signed [DW-1:0] s;
    s = d;
    if (mode == 2'b10)      return d >> amt;
    else if (mode == 2'b11) return DW'(s >>> amt);
    else                    return d << amt;
  endfunction

  function automatic int ref_latency(input int amt);
    return (amt == 0) ? 1 : (amt + SA - 1) / SA + 1;
  endfunction

  bit            m_inflight = 1'b0;
  int            m_wait     = 0;     // edges left until the response shows
  logic [DW-1:0] m_result   = '0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_inflight = 1'b0;
      m_wait     = 0;
      m_result   = '0;
    end else if (kill_i) begin
      m_inflight = 1'b0;
    end else if (!m_inflight) begin
      if (req_valid_i) begin
        m_inflight = 1'b1;
        m_wait     = ref_latency(int'(req_amt_i)) - 1;
        m_result   = ref_shift(req_data_i, int'(req_amt_i), req_mode_i);
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (rsp_ready_i) begin
      m_inflight = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (chk_en && rst_ni) begin
      check("model req_ready", req_ready_o, !m_inflight);
      check("model busy", busy_o, m_inflight);
      check("model rsp_valid", rsp_valid_o, m_inflight && (m_wait == 0));
      if (m_inflight && (m_wait == 0))
        check("model rsp_result", rsp_result_o, m_result);
    end
  end

  // Called at posedge+2 with the unit idle. The task returns at posedge+2.
  task automatic run_req(input string name, input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input logic [1:0] m, input logic [DW-1:0] exp_res,
                         input int exp_lat, input int hold);
    int lat;
    bit got;
    req_data_i  = d;
    req_amt_i   = a;
    req_mode_i  = m;
    req_valid_i = 1'b1;
    rsp_ready_i = (hold == 0);
    @(posedge clk_i);
    #2 req_valid_i = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) begin
      check({name, " response timeout"}, 0, 1);
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #2;
      return;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, rsp_result_o, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check({name, " held result"}, rsp_result_o, exp_res);
      check({name, " held valid"}, rsp_valid_o, 1);
      check({name, " held req_ready"}, req_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #2;
    check({name, " idle after"}, busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset req_ready", req_ready_o, 1);
    check("reset rsp_valid", rsp_valid_o, 0);
    check("reset busy", busy_o, 0);
    check("reset result", rsp_result_o, 0);
    #1 rst_ni = 1'b1;
    chk_en = 1'b1;
    @(posedge clk_i);
    #2;

    run_req("sll 1 by 31",      32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 9, 0);
    run_req("sra 8000 by 4",    32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000, 2, 0);
    run_req("srl 8000 by 4",    32'h8000_0000, 5'd4,  2'b10, 32'h0800_0000, 2, 0);
    run_req("mode01 left",      32'h0000_0001, 5'd3,  2'b01, 32'h0000_0008, 2, 0);
    run_req("sra 8000 by 31",   32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 9, 0);
    run_req("srl backpressure", 32'hF000_000F, 5'd5,  2'b10, 32'h0780_0000, 3, 3);

    // Kill during the second SHIFT cycle.
    req_data_i = 32'h1; req_amt_i = 5'd20; req_mode_i = 2'b00; req_valid_i = 1'b1;
    @(posedge clk_i);
    #2 req_valid_i = 1'b0;
    @(posedge clk_i);
    #2 kill_i = 1'b1;
    @(posedge clk_i);
    #2 kill_i = 1'b0;
    check("kill busy", busy_o, 0);
    check("kill rsp_valid", rsp_valid_o, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check("kill no response", rsp_valid_o, 0);
    end
    @(posedge clk_i);
    #2;
    run_req("sll 3 after kill", 32'h0000_0003, 5'd1, 2'b00, 32'h0000_0006, 2, 0);

    // A request in the same cycle as kill is void.
    req_data_i = 32'h5; req_amt_i = 5'd2; req_valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i);
    #2 req_valid_i = 1'b0; kill_i = 1'b0;
    check("kill+req busy", busy_o, 0);
    check("kill+req rsp_valid", rsp_valid_o, 0);

    // Kill in DONE together with rsp_ready: the response is dropped.
    req_data_i = 32'h1234_5678; req_amt_i = 5'd0; req_mode_i = 2'b00;
    req_valid_i = 1'b1; rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #2 req_valid_i = 1'b0; kill_i = 1'b1;
    @(posedge clk_i);
    #2 kill_i = 1'b0;
    check("kill in done busy", busy_o, 0);
    check("kill in done rsp_valid", rsp_valid_o, 0);
    @(posedge clk_i);
    #2;

    // Asynchronous reset in the middle of a SHIFT sequence.
    req_data_i = 32'h1; req_amt_i = 5'd31; req_mode_i = 2'b00; req_valid_i = 1'b1;
    @(posedge clk_i);
    #2 req_valid_i = 1'b0;
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    check("async rst req_ready", req_ready_o, 1);
    check("async rst rsp_valid", rsp_valid_o, 0);
    check("async rst busy", busy_o, 0);
    check("async rst result", rsp_result_o, 0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #2;

    run_req("zero amt sra", 32'hDEAD_BEEF, 5'd0, 2'b11, 32'hDEAD_BEEF, 1, 0);
    run_req("zero amt sll", 32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF, 1, 0);

    repeat (2) @(posedge clk_i);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
